// File: rtl/i2s_stream_pkg.sv
// Shared types and frame geometry for the I2S sample streamer.
package i2s_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int unsigned SLOTS_PER_FRAME = 64;
  localparam int unsigned SLOT_W          = 6;

  // First BCLK slot carrying the MSB of each lane (one slot after the LRCK edge).
  localparam logic [SLOT_W-1:0] LEFT_FIRST_SLOT  = 6'd1;
  localparam logic [SLOT_W-1:0] RIGHT_FIRST_SLOT = 6'd33;

  // Last slot of a frame and the slot where the right word is fetched.
  localparam logic [SLOT_W-1:0] LAST_SLOT      = SLOT_W'(SLOTS_PER_FRAME - 1);
  localparam logic [SLOT_W-1:0] RIGHT_POP_SLOT = SLOT_W'(SLOTS_PER_FRAME / 2);

endpackage

// File: rtl/i2s_sample_streamer_if.sv
// FIFO read side plus the I2S serial lane, bundled for the streamer.
interface i2s_sample_streamer_if #(
  parameter int unsigned SAMPLE_W = 24
);

  logic [SAMPLE_W-1:0] fifo_dout;
  logic                fifo_hw;
  logic                fifo_lw;
  logic                fifo_pop;
  logic                i2s_bclk;
  logic                i2s_lrck;
  logic                i2s_sdata;

  // Streamer side: consumes FIFO words, drives the serial lane.
  modport master (
    input  fifo_dout, fifo_hw, fifo_lw,
    output fifo_pop, i2s_bclk, i2s_lrck, i2s_sdata
  );

  // FIFO / codec side.
  modport slave (
    output fifo_dout, fifo_hw, fifo_lw,
    input  fifo_pop, i2s_bclk, i2s_lrck, i2s_sdata
  );

endinterface

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: registered bit clock plus a strobe marking its falling edge.
module i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 23
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int unsigned      DIV_W    = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             term;

  // Next divider count and bit-clock level; clear parks both at zero.
  always_comb begin
    term   = (div_q == DIV_LAST);
    div_d  = div_q + DIV_W'(1);
    bclk_d = bclk_q;
    if (term) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end
    if (clr_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end
  end

  // Divider and bit-clock registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  // High in the cycle whose closing edge drives BCLK low, so the caller can
  // advance its slot on that same edge.
  assign fall_o = term & bclk_q;

endmodule

// File: rtl/i2s_sample_streamer.sv
// Pops left/right words from the sample FIFO and serialises them as a
// 64-slot I2S frame; tracks refill requests and FIFO starvation.
module i2s_sample_streamer
  import i2s_stream_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 23,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk143,
  input  logic                         rst_n,
  input  logic                         enable,
  i2s_sample_streamer_if.master        bus,
  output logic                         refill_req,
  output logic                         running,
  output logic [CNT_W-1:0]             underrun_cnt
);

  localparam logic [SLOT_W-1:0] LEFT_LAST_SLOT  = LEFT_FIRST_SLOT  + SLOT_W'(SAMPLE_W - 1);
  localparam logic [SLOT_W-1:0] RIGHT_LAST_SLOT = RIGHT_FIRST_SLOT + SLOT_W'(SAMPLE_W - 1);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d, slot_nx;
  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic [SAMPLE_W-1:0] left_sh, right_sh;
  logic                pop_q, pop_d;
  logic                lrck_q, lrck_d;
  logic                sdata_q, sdata_d;
  logic                refill_q, refill_d;
  logic                running_q, running_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ser_bit;
  logic                bclk, fall, clr;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk (
    .clk_i  (clk143),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .bclk_o (bclk),
    .fall_o (fall)
  );

  // FSM state register.
  always_ff @(posedge clk143 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, slot advance, pops, serialiser mux and counters.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    left_d   = left_q;
    right_d  = right_q;
    pop_d    = 1'b0;
    lrck_d   = lrck_q;
    sdata_d  = sdata_q;
    cnt_d    = cnt_q;
    refill_d = refill_q;
    clr      = 1'b1;

    // Bit for the slot being entered: MSB lands one slot after the LRCK edge.
    slot_nx  = slot_q + SLOT_W'(1);
    left_sh  = left_q  >> (LEFT_LAST_SLOT  - slot_nx);
    right_sh = right_q >> (RIGHT_LAST_SLOT - slot_nx);
    ser_bit  = 1'b0;
    if (slot_nx >= LEFT_FIRST_SLOT && slot_nx <= LEFT_LAST_SLOT) begin
      ser_bit = left_sh[0];
    end else if (slot_nx >= RIGHT_FIRST_SLOT && slot_nx <= RIGHT_LAST_SLOT) begin
      ser_bit = right_sh[0];
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!bus.fifo_lw) begin
          // Entry edge doubles as "entering slot 0".
          state_d = RUN;
          slot_d  = '0;
          lrck_d  = 1'b0;
          sdata_d = 1'b0;
          pop_d   = 1'b1;
          left_d  = bus.fifo_dout;
        end
      end
      RUN: begin
        clr = 1'b0;
        if (fall) begin
          if (slot_q == LAST_SLOT && !enable) begin
            // Stop exactly where slot 0 would begin: no pop, lane parked low.
            state_d = IDLE;
            slot_d  = '0;
            lrck_d  = 1'b0;
            sdata_d = 1'b0;
            clr     = 1'b1;
          end else begin
            slot_d  = slot_nx;
            lrck_d  = slot_nx[SLOT_W-1];
            sdata_d = ser_bit;
            if (slot_nx == '0) begin
              pop_d  = 1'b1;
              left_d = bus.fifo_dout;
            end
            if (slot_nx == RIGHT_POP_SLOT) begin
              pop_d   = 1'b1;
              right_d = bus.fifo_dout;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop_d && bus.fifo_lw && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);

    if (bus.fifo_hw || state_q == IDLE) refill_d = 1'b0;
    else if (bus.fifo_lw)               refill_d = 1'b1;

    running_d = (state_d == RUN);
  end

  // Datapath and output registers.
  always_ff @(posedge clk143 or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      pop_q     <= 1'b0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      refill_q  <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      slot_q    <= slot_d;
      left_q    <= left_d;
      right_q   <= right_d;
      pop_q     <= pop_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      refill_q  <= refill_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.fifo_pop  = pop_q;
  assign bus.i2s_bclk  = bclk;
  assign bus.i2s_lrck  = lrck_q;
  assign bus.i2s_sdata = sdata_q;
  assign refill_req    = refill_q;
  assign running       = running_q;
  assign underrun_cnt  = cnt_q;

endmodule

// File: tb/tb_i2s_sample_streamer.sv
// Bench for i2s_sample_streamer at BCLK_DIV=2: scoreboard of popped words
// against the deserialised I2S lane, plus per-feature scenario tasks.
module tb_i2s_sample_streamer;

  localparam int unsigned BCLK_DIV = 2;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned CNT_W    = 16;
  localparam int          HALF_CYC = 128;  // 32 slots * 2 * BCLK_DIV

  logic                clk143 = 1'b0;
  logic                rst_n  = 1'b0;
  logic                enable = 1'b0;
  logic                fifo_hw = 1'b0;
  logic                fifo_lw = 1'b0;
  logic [SAMPLE_W-1:0] dout_v = '0;

  logic             refill_req, running;
  logic [CNT_W-1:0] underrun_cnt;
  logic             refill_sat, running_sat;
  logic [1:0]       cnt_sat;

  i2s_sample_streamer_if #(.SAMPLE_W(SAMPLE_W)) bus ();
  i2s_sample_streamer_if #(.SAMPLE_W(SAMPLE_W)) bus_sat ();

  assign bus.fifo_dout     = dout_v;
  assign bus.fifo_hw       = fifo_hw;
  assign bus.fifo_lw       = fifo_lw;
  assign bus_sat.fifo_dout = dout_v;
  assign bus_sat.fifo_hw   = fifo_hw;
  assign bus_sat.fifo_lw   = fifo_lw;

  i2s_sample_streamer #(.BCLK_DIV(BCLK_DIV), .SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W)) dut (
    .clk143       (clk143),
    .rst_n        (rst_n),
    .enable       (enable),
    .bus          (bus),
    .refill_req   (refill_req),
    .running      (running),
    .underrun_cnt (underrun_cnt)
  );

  i2s_sample_streamer #(.BCLK_DIV(BCLK_DIV), .SAMPLE_W(SAMPLE_W), .CNT_W(2)) dut_sat (
    .clk143       (clk143),
    .rst_n        (rst_n),
    .enable       (enable),
    .bus          (bus_sat),
    .refill_req   (refill_sat),
    .running      (running_sat),
    .underrun_cnt (cnt_sat)
  );

  always #5 clk143 = ~clk143;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk143) cyc++;

  typedef struct packed {
    logic                side;
    logic [SAMPLE_W-1:0] word;
  } exp_t;

  exp_t                exp_q[$];
  logic [SAMPLE_W-1:0] src_q[$];
  exp_t                mon_e;
  int                  mon_slot      = 0;
  bit                  mon_active    = 1'b0;
  logic                prev_bclk     = 1'b0;
  logic                exp_side      = 1'b0;
  logic [SAMPLE_W-1:0] shreg         = '0;
  int                  words_checked = 0;
  int                  pops_seen     = 0;

  task automatic refresh_dout();
    dout_v = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(SAMPLE_W'($urandom));
    refresh_dout();
  endtask

  // Scoreboard: a pop pushes the word the FIFO model presented; the lane
  // monitor pops it back when the last bit of that lane has been received.
  always @(negedge clk143) begin
    if (!rst_n) begin
      mon_active = 1'b0;
      prev_bclk  = 1'b0;
      exp_side   = 1'b0;
      exp_q.delete();
    end else begin
      if (!running) begin
        mon_active = 1'b0;
        exp_side   = 1'b0;
      end
      if (bus.fifo_pop) begin
        exp_q.push_back('{side: exp_side, word: dout_v});
        exp_side = ~exp_side;
        pops_seen++;
        if (src_q.size() > 0) void'(src_q.pop_front());
        refresh_dout();
      end
      if (bus.i2s_bclk && !prev_bclk) begin
        if (!mon_active) begin
          mon_slot   = 0;
          mon_active = 1'b1;
        end else begin
          mon_slot = (mon_slot + 1) % 64;
        end
        vectors++;
        if (bus.i2s_lrck !== (mon_slot >= 32)) begin
          miscompares++;
          $display("FAIL lrck slot %0d: got %b expected %b", mon_slot, bus.i2s_lrck, (mon_slot >= 32));
        end
        if ((mon_slot >= 1 && mon_slot <= 24) || (mon_slot >= 33 && mon_slot <= 56)) begin
          shreg = {shreg[SAMPLE_W-2:0], bus.i2s_sdata};
          if (mon_slot == 24 || mon_slot == 56) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL word slot %0d: got %h expected a popped word, scoreboard empty", mon_slot, shreg);
            end else begin
              mon_e = exp_q.pop_front();
              if (shreg !== mon_e.word || mon_e.side !== (mon_slot == 56)) begin
                miscompares++;
                $display("FAIL word slot %0d: got %h expected %h (side %b)", mon_slot, shreg, mon_e.word, mon_e.side);
              end
              words_checked++;
            end
          end
        end else begin
          vectors++;
          if (bus.i2s_sdata !== 1'b0) begin
            miscompares++;
            $display("FAIL pad slot %0d: got sdata %b expected 0", mon_slot, bus.i2s_sdata);
          end
        end
      end
      prev_bclk = bus.i2s_bclk;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; fifo_lw = 1'b0; fifo_hw = 1'b0;
    repeat (3) @(posedge clk143);
    @(negedge clk143);
    vectors++;
    if ({bus.fifo_pop, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata, refill_req, running} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.fifo_pop, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata, refill_req, running});
    end
    vectors++;
    if (underrun_cnt !== 16'd0 || cnt_sat !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d/%0d expected 0/0", underrun_cnt, cnt_sat);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_prime();
    src_q.delete();
    src_q.push_back(24'hA5C3F0);
    src_q.push_back(24'h123456);
    load_words(48);
    enable  = 1'b1;
    fifo_lw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk143);
      vectors++;
      if ({running, bus.fifo_pop, bus.i2s_bclk} !== 3'b000) begin
        miscompares++;
        $display("FAIL prime_hold cycle %0d: got run/pop/bclk %b expected 000", i,
                 {running, bus.fifo_pop, bus.i2s_bclk});
      end
    end
    vectors++;
    if (refill_req !== 1'b1) begin
      miscompares++;
      $display("FAIL prime_refill: got %b expected 1", refill_req);
    end
    fifo_lw = 1'b0;
    @(negedge clk143);
    vectors++;
    if (running !== 1'b1 || bus.fifo_pop !== 1'b1) begin
      miscompares++;
      $display("FAIL run_entry: got running %b pop %b expected 1 1", running, bus.fifo_pop);
    end
  endtask

  task automatic test_serial();
    int last_rise;
    bit have_rise;
    logic pb;
    have_rise = 1'b0;
    last_rise = 0;
    pb = bus.i2s_bclk;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk143);
      if (bus.i2s_bclk && !pb) begin
        if (have_rise) begin
          vectors++;
          if (cyc - last_rise !== 2 * BCLK_DIV) begin
            miscompares++;
            $display("FAIL bclk_period: got %0d expected %0d", cyc - last_rise, 2 * BCLK_DIV);
          end
        end
        have_rise = 1'b1;
        last_rise = cyc;
      end
      pb = bus.i2s_bclk;
    end
    for (int i = 0; i < 400 && words_checked < 2; i++) @(negedge clk143);
    vectors++;
    if (words_checked !== 2) begin
      miscompares++;
      $display("FAIL first_frame_words: got %0d expected 2", words_checked);
    end
  endtask

  task automatic test_pop_spacing();
    int   count, last;
    logic prev_pop;
    for (int i = 0; i < 300 && !bus.fifo_pop; i++) @(negedge clk143);
    vectors++;
    if (bus.fifo_pop !== 1'b1) begin
      miscompares++;
      $display("FAIL pop_wait: got pop %b expected 1 within 300 cycles", bus.fifo_pop);
    end
    count = 1;
    last = cyc;
    prev_pop = 1'b1;
    for (int i = 1; i < 20 * HALF_CYC; i++) begin
      @(negedge clk143);
      if (prev_pop) begin
        vectors++;
        if (bus.fifo_pop !== 1'b0) begin
          miscompares++;
          $display("FAIL pop_width: got pop %b expected 0 after one cycle", bus.fifo_pop);
        end
      end else if (bus.fifo_pop) begin
        vectors++;
        if (cyc - last !== HALF_CYC) begin
          miscompares++;
          $display("FAIL pop_spacing: got %0d expected %0d", cyc - last, HALF_CYC);
        end
        count++;
        last = cyc;
      end
      prev_pop = bus.fifo_pop;
    end
    vectors++;
    if (count !== 20) begin
      miscompares++;
      $display("FAIL pop_count_10_frames: got %0d expected 20", count);
    end
  endtask

  task automatic test_stop();
    int p0, last_slot, bad;
    for (int i = 0; i < 300 && !(mon_active && mon_slot == 10); i++) @(negedge clk143);
    enable = 1'b0;
    p0 = pops_seen;
    last_slot = mon_slot;
    for (int i = 0; i < 400 && running; i++) begin
      last_slot = mon_slot;
      @(negedge clk143);
    end
    vectors++;
    if (running !== 1'b0 || last_slot !== 63) begin
      miscompares++;
      $display("FAIL stop_frame_end: got running %b last slot %0d expected 0 63", running, last_slot);
    end
    vectors++;
    if (pops_seen - p0 !== 1 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL stop_pops: got %0d pops, %0d pending expected 1 pop, 0 pending",
               pops_seen - p0, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk143);
      if ({bus.fifo_pop, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata, running} !== 5'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL stop_idle_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_underrun();
    int p0;
    load_words(24);
    p0 = pops_seen;
    enable = 1'b1;
    for (int i = 0; i < 10 && !running; i++) @(negedge clk143);
    fifo_lw = 1'b1;
    for (int i = 0; i < 1000 && (pops_seen - p0) < 7; i++) @(negedge clk143);
    fifo_lw = 1'b0;
    vectors++;
    if (underrun_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL underrun_count: got %0d expected 6", underrun_cnt);
    end
    vectors++;
    if (cnt_sat !== 2'd3) begin
      miscompares++;
      $display("FAIL underrun_saturate: got %0d expected 3", cnt_sat);
    end
    vectors++;
    if (refill_req !== 1'b1) begin
      miscompares++;
      $display("FAIL refill_set: got %b expected 1", refill_req);
    end
    fifo_hw = 1'b1;
    @(negedge clk143);
    vectors++;
    if (refill_req !== 1'b0 || refill_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL refill_clear: got %b/%b expected 0/0", refill_req, refill_sat);
    end
    fifo_hw = 1'b0;
    repeat (2) @(negedge clk143);
    vectors++;
    if (refill_req !== 1'b0 || underrun_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL refill_hold: got refill %b count %0d expected 0 6", refill_req, underrun_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    for (int i = 0; i < 300 && !(mon_active && mon_slot == 40); i++) @(negedge clk143);
    @(negedge clk143);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.fifo_pop, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata, refill_req, running} !== 6'b0
        || underrun_cnt !== 16'd0 || cnt_sat !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %b cnt %0d expected all 0",
               {bus.fifo_pop, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata, refill_req, running}, underrun_cnt);
    end
    fifo_lw = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk143);
      if (bus.fifo_pop !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk143);
      if (bus.fifo_pop !== 1'b0 || running !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL reset_no_pop: got %0d bad cycles expected 0", bad);
    end
    vectors++;
    if (refill_req !== 1'b1) begin
      miscompares++;
      $display("FAIL reprime: got refill %b expected 1 (PRIME with low watermark)", refill_req);
    end
    enable  = 1'b0;
    fifo_lw = 1'b0;
    repeat (3) @(negedge clk143);
    vectors++;
    if (refill_req !== 1'b0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_idle: got refill %b running %b expected 0 0", refill_req, running);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_prime();
    test_serial();
    test_pop_spacing();
    test_stop();
    test_underrun();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
